// File: rtl/mxbus_timer.sv
// mxbus_timer: MX bus responder exposing a programmable 8-bit down-counter timer
// with prescaler, auto-reload and a level interrupt to the mx11su core.
module mxbus_timer #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s0_wr_txn_start,
   input  logic [ADDR_WIDTH-1:0] s0_wr_addr,
   input  logic [DATA_WIDTH-1:0] s0_wr_data,
   output logic                  s0_wr_ready,
   output logic                  s0_wr_txn_ack,
   output logic                  s0_wr_txn_cpl,
   input  logic                  s0_rd_txn_start,
   input  logic [ADDR_WIDTH-1:0] s0_rd_addr,
   output logic [DATA_WIDTH-1:0] s0_rd_data,
   output logic                  s0_rd_ready,
   output logic                  s0_rd_txn_ack,
   output logic                  s0_rd_txn_cpl,
   output logic                  irq
);

   localparam int unsigned OFF_W = 3;
   localparam logic [OFF_W-1:0] OFF_CTRL     = 3'd0;
   localparam logic [OFF_W-1:0] OFF_STATUS   = 3'd1;
   localparam logic [OFF_W-1:0] OFF_RELOAD   = 3'd2;
   localparam logic [OFF_W-1:0] OFF_COUNT    = 3'd3;
   localparam logic [OFF_W-1:0] OFF_PRESCALE = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACK  = 2'd1,
      ST_CPL  = 2'd2
   } chan_st_e;

   // Write channel state
   chan_st_e              wr_st_q;
   logic                  wr_ready_q, wr_ack_q, wr_cpl_q;
   logic [OFF_W-1:0]      wr_off_q;
   logic [DATA_WIDTH-1:0] wr_data_q;
   logic                  wr_commit;

   // Read channel state
   chan_st_e              rd_st_q;
   logic                  rd_ready_q, rd_ack_q, rd_cpl_q;
   logic [OFF_W-1:0]      rd_off_q;
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic [DATA_WIDTH-1:0] rd_mux;

   // Timer registers
   logic                  en_q, en_d;
   logic                  auto_q, auto_d;
   logic                  irq_en_q, irq_en_d;
   logic                  expired_q, expired_d;
   logic [DATA_WIDTH-1:0] reload_q, reload_d;
   logic [DATA_WIDTH-1:0] prescale_q, prescale_d;
   logic [DATA_WIDTH-1:0] count_q, count_d;
   logic [DATA_WIDTH-1:0] pcnt_q, pcnt_d;
   logic                  tick;
   logic                  irq_q;

   // Only the register offset is decoded; upstream has already selected this block.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{s0_wr_addr[ADDR_WIDTH-1:OFF_W], s0_rd_addr[ADDR_WIDTH-1:OFF_W]};

   // Write channel IDLE -> ACK -> CPL; offset and data captured on acceptance
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_st_q    <= ST_IDLE;
         wr_ready_q <= 1'b0;
         wr_ack_q   <= 1'b0;
         wr_cpl_q   <= 1'b0;
         wr_off_q   <= '0;
         wr_data_q  <= '0;
      end else begin
         wr_ack_q <= 1'b0;
         wr_cpl_q <= 1'b0;
         case (wr_st_q)
            ST_IDLE: begin
               if (s0_wr_txn_start && wr_ready_q) begin
                  wr_st_q    <= ST_ACK;
                  wr_ack_q   <= 1'b1;
                  wr_ready_q <= 1'b0;
                  wr_off_q   <= s0_wr_addr[OFF_W-1:0];
                  wr_data_q  <= s0_wr_data;
               end else begin
                  wr_ready_q <= 1'b1;
               end
            end
            ST_ACK: begin
               wr_st_q  <= ST_CPL;
               wr_cpl_q <= 1'b1;
            end
            ST_CPL: begin
               wr_st_q    <= ST_IDLE;
               wr_ready_q <= 1'b1;
            end
            default: begin
               wr_st_q    <= ST_IDLE;
               wr_ready_q <= 1'b1;
            end
         endcase
      end
   end

   // Register update lands at the end of the write CPL cycle
   assign wr_commit = (wr_st_q == ST_CPL);

   // Read channel IDLE -> ACK -> CPL; data sampled during ACK, held until next read
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_st_q    <= ST_IDLE;
         rd_ready_q <= 1'b0;
         rd_ack_q   <= 1'b0;
         rd_cpl_q   <= 1'b0;
         rd_off_q   <= '0;
         rd_data_q  <= '0;
      end else begin
         rd_ack_q <= 1'b0;
         rd_cpl_q <= 1'b0;
         case (rd_st_q)
            ST_IDLE: begin
               if (s0_rd_txn_start && rd_ready_q) begin
                  rd_st_q    <= ST_ACK;
                  rd_ack_q   <= 1'b1;
                  rd_ready_q <= 1'b0;
                  rd_off_q   <= s0_rd_addr[OFF_W-1:0];
               end else begin
                  rd_ready_q <= 1'b1;
               end
            end
            ST_ACK: begin
               rd_st_q   <= ST_CPL;
               rd_cpl_q  <= 1'b1;
               rd_data_q <= rd_mux;
            end
            ST_CPL: begin
               rd_st_q    <= ST_IDLE;
               rd_ready_q <= 1'b1;
            end
            default: begin
               rd_st_q    <= ST_IDLE;
               rd_ready_q <= 1'b1;
            end
         endcase
      end
   end

   // Register read mux; unmapped offsets read as zero
   always_comb begin
      rd_mux = '0;
      case (rd_off_q)
         OFF_CTRL:     rd_mux = DATA_WIDTH'({irq_en_q, auto_q, en_q});
         OFF_STATUS:   rd_mux = DATA_WIDTH'(expired_q);
         OFF_RELOAD:   rd_mux = reload_q;
         OFF_COUNT:    rd_mux = count_q;
         OFF_PRESCALE: rd_mux = prescale_q;
         default:      rd_mux = '0;
      endcase
   end

   // Timer next state: bus writes first, then prescaler/tick so an expiry beats a W1C
   always_comb begin
      en_d       = en_q;
      auto_d     = auto_q;
      irq_en_d   = irq_en_q;
      expired_d  = expired_q;
      reload_d   = reload_q;
      prescale_d = prescale_q;
      count_d    = count_q;
      pcnt_d     = pcnt_q;
      tick       = 1'b0;

      if (wr_commit) begin
         case (wr_off_q)
            OFF_CTRL: begin
               en_d     = wr_data_q[0];
               auto_d   = wr_data_q[1];
               irq_en_d = wr_data_q[2];
               if (wr_data_q[0] && !en_q) begin
                  count_d = reload_q;
                  pcnt_d  = '0;
               end
            end
            OFF_STATUS:   if (wr_data_q[0]) expired_d = 1'b0;
            OFF_RELOAD:   reload_d = wr_data_q;
            OFF_PRESCALE: prescale_d = wr_data_q;
            default:      ;
         endcase
      end

      if (en_q) begin
         if (pcnt_q == prescale_q) begin
            pcnt_d = '0;
            tick   = 1'b1;
         end else begin
            pcnt_d = pcnt_q + DATA_WIDTH'(1);
         end
      end

      if (tick) begin
         if (count_q != '0) begin
            count_d = count_q - DATA_WIDTH'(1);
         end else begin
            expired_d = 1'b1;
            if (auto_q) count_d = reload_q;
            else        en_d    = 1'b0;
         end
      end
   end

   // Timer register bank and registered interrupt
   always_ff @(posedge clk) begin
      if (rst) begin
         en_q       <= 1'b0;
         auto_q     <= 1'b0;
         irq_en_q   <= 1'b0;
         expired_q  <= 1'b0;
         reload_q   <= '0;
         prescale_q <= '0;
         count_q    <= '0;
         pcnt_q     <= '0;
         irq_q      <= 1'b0;
      end else begin
         en_q       <= en_d;
         auto_q     <= auto_d;
         irq_en_q   <= irq_en_d;
         expired_q  <= expired_d;
         reload_q   <= reload_d;
         prescale_q <= prescale_d;
         count_q    <= count_d;
         pcnt_q     <= pcnt_d;
         irq_q      <= expired_q & irq_en_q;
      end
   end

   assign s0_wr_ready   = wr_ready_q;
   assign s0_wr_txn_ack = wr_ack_q;
   assign s0_wr_txn_cpl = wr_cpl_q;
   assign s0_rd_ready   = rd_ready_q;
   assign s0_rd_txn_ack = rd_ack_q;
   assign s0_rd_txn_cpl = rd_cpl_q;
   assign s0_rd_data    = rd_data_q;
   assign irq           = irq_q;

endmodule

// File: tb/tb_mxbus_timer.sv
// tb_mxbus_timer: directed bench for mxbus_timer with a read-data scoreboard.
module tb_mxbus_timer;

   localparam int unsigned ADDR_WIDTH = 8;
   localparam int unsigned DATA_WIDTH = 8;

   logic                  clk;
   logic                  rst;
   logic                  s0_wr_txn_start;
   logic [ADDR_WIDTH-1:0] s0_wr_addr;
   logic [DATA_WIDTH-1:0] s0_wr_data;
   logic                  s0_wr_ready, s0_wr_txn_ack, s0_wr_txn_cpl;
   logic                  s0_rd_txn_start;
   logic [ADDR_WIDTH-1:0] s0_rd_addr;
   logic [DATA_WIDTH-1:0] s0_rd_data;
   logic                  s0_rd_ready, s0_rd_txn_ack, s0_rd_txn_cpl;
   logic                  irq;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   logic [DATA_WIDTH-1:0] exp_q[$];

   mxbus_timer #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) dut (
      .clk             (clk),
      .rst             (rst),
      .s0_wr_txn_start (s0_wr_txn_start),
      .s0_wr_addr      (s0_wr_addr),
      .s0_wr_data      (s0_wr_data),
      .s0_wr_ready     (s0_wr_ready),
      .s0_wr_txn_ack   (s0_wr_txn_ack),
      .s0_wr_txn_cpl   (s0_wr_txn_cpl),
      .s0_rd_txn_start (s0_rd_txn_start),
      .s0_rd_addr      (s0_rd_addr),
      .s0_rd_data      (s0_rd_data),
      .s0_rd_ready     (s0_rd_ready),
      .s0_rd_txn_ack   (s0_rd_txn_ack),
      .s0_rd_txn_cpl   (s0_rd_txn_cpl),
      .irq             (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle index: value seen #1 after a rising edge names the cycle that edge starts
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: pop the oldest expected read value whenever a read completes
   always @(posedge clk) begin
      #1;
      if (s0_rd_txn_cpl === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("rd_unexpected_cpl", 32'(s0_rd_data), 32'hFFFF_FFFF);
         end else begin
            chk("rd_data", 32'(s0_rd_data), 32'(exp_q.pop_front()));
         end
      end
   end

   // Write starting in the current cycle k; returns at k+3 with the CPL cycle index
   task automatic wr(input logic [7:0] a, input logic [7:0] d, output int cpl_cyc);
      s0_wr_txn_start = 1'b1;
      s0_wr_addr      = a;
      s0_wr_data      = d;
      step();
      s0_wr_txn_start = 1'b0;
      chk("wr_ack", 32'(s0_wr_txn_ack), 32'd1);
      chk("wr_ready_in_ack", 32'(s0_wr_ready), 32'd0);
      chk("wr_cpl_in_ack", 32'(s0_wr_txn_cpl), 32'd0);
      step();
      chk("wr_cpl", 32'(s0_wr_txn_cpl), 32'd1);
      chk("wr_ack_in_cpl", 32'(s0_wr_txn_ack), 32'd0);
      chk("wr_ready_in_cpl", 32'(s0_wr_ready), 32'd0);
      cpl_cyc = cyc;
      step();
      chk("wr_ready_after", 32'(s0_wr_ready), 32'd1);
      chk("wr_cpl_after", 32'(s0_wr_txn_cpl), 32'd0);
   endtask

   // Read starting in the current cycle; expected data goes to the scoreboard
   task automatic rd(input logic [7:0] a, input logic [7:0] e);
      exp_q.push_back(e);
      s0_rd_txn_start = 1'b1;
      s0_rd_addr      = a;
      step();
      s0_rd_txn_start = 1'b0;
      chk("rd_ack", 32'(s0_rd_txn_ack), 32'd1);
      chk("rd_ready_in_ack", 32'(s0_rd_ready), 32'd0);
      step();
      chk("rd_cpl", 32'(s0_rd_txn_cpl), 32'd1);
      chk("rd_ready_in_cpl", 32'(s0_rd_ready), 32'd0);
      step();
      chk("rd_ready_after", 32'(s0_rd_ready), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c;
      int t0;
      rst             = 1'b1;
      s0_wr_txn_start = 1'b0;
      s0_wr_addr      = '0;
      s0_wr_data      = '0;
      s0_rd_txn_start = 1'b0;
      s0_rd_addr      = '0;

      // Reset held for three edges: every output low
      repeat (3) begin
         step();
         chk("reset_outputs",
             32'({s0_wr_ready, s0_wr_txn_ack, s0_wr_txn_cpl, s0_rd_ready,
                  s0_rd_txn_ack, s0_rd_txn_cpl, irq, s0_rd_data}), 32'd0);
      end
      rst = 1'b0;
      step();
      chk("wr_ready_post_reset", 32'(s0_wr_ready), 32'd1);
      chk("rd_ready_post_reset", 32'(s0_rd_ready), 32'd1);
      for (int i = 0; i < 5; i++) rd(8'(i), 8'h00);

      // Handshake, offset-only decode, read-only COUNT
      wr(8'd2, 8'h5A, c);
      rd(8'd2, 8'h5A);
      rd(8'hA2, 8'h5A);
      wr(8'd3, 8'h12, c);
      rd(8'd3, 8'h00);

      // One-shot: CTRL commits at end of C; ticks C+1..C+4, expired seen C+5, irq C+6
      wr(8'd2, 8'd3, c);
      wr(8'd4, 8'd0, c);
      wr(8'd0, 8'h05, c);
      while (cyc < c + 5) step();
      chk("oneshot_irq_early", 32'(irq), 32'd0);
      step();
      chk("oneshot_irq", 32'(irq), 32'd1);
      rd(8'd0, 8'h04);
      rd(8'd3, 8'h00);
      rd(8'd1, 8'h01);
      wr(8'd1, 8'h01, c);
      step();
      chk("oneshot_w1c_irq_low", 32'(irq), 32'd0);

      // Auto-reload, PRESCALE=2: expiry ticks at t0+6, +12, +18, +24; irq rises 2 later
      wr(8'd2, 8'd1, c);
      wr(8'd4, 8'd2, c);
      wr(8'd0, 8'h07, c);
      t0 = c;
      while (cyc < t0 + 7) step();
      chk("auto_irq_early", 32'(irq), 32'd0);
      step();
      chk("auto_irq_first", 32'(irq), 32'd1);
      // W1C committed at t0+12, the same cycle as an expiry: set wins
      while (cyc < t0 + 10) step();
      wr(8'd1, 8'h01, c);
      step();
      chk("setwins_irq", 32'(irq), 32'd1);
      rd(8'd1, 8'h01);
      // W1C committed at t0+21, away from expiries: clears
      while (cyc < t0 + 19) step();
      wr(8'd1, 8'h01, c);
      step();
      chk("auto_w1c_irq_low", 32'(irq), 32'd0);
      step();
      step();
      chk("auto_irq_before_next", 32'(irq), 32'd0);
      step();
      chk("auto_irq_period", 32'(irq), 32'd1);
      wr(8'd0, 8'h00, c);

      // Concurrent STATUS read and W1C: read sees the pre-write value
      fork
         wr(8'd1, 8'h01, c);
         rd(8'd1, 8'h01);
      join
      rd(8'd1, 8'h00);
      chk("irq_disabled", 32'(irq), 32'd0);

      // Unmapped offset: handshakes complete, reads zero
      wr(8'd6, 8'hFF, c);
      rd(8'd6, 8'h00);

      // Abort: reset during the ACK cycle of a RELOAD write
      s0_wr_txn_start = 1'b1;
      s0_wr_addr      = 8'd2;
      s0_wr_data      = 8'h77;
      step();
      s0_wr_txn_start = 1'b0;
      chk("abort_ack", 32'(s0_wr_txn_ack), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_no_cpl", 32'(s0_wr_txn_cpl), 32'd0);
      chk("abort_ready_low", 32'(s0_wr_ready), 32'd0);
      step();
      chk("abort_no_cpl_late", 32'(s0_wr_txn_cpl), 32'd0);
      chk("abort_ready_back", 32'(s0_wr_ready), 32'd1);
      rd(8'd2, 8'h00);

      step();
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
